// File: rtl/game_pkg.sv
// Shared game types: symbols, sequence indices and the player state encoding.
package game_pkg;

    typedef logic [2:0] sym_t;
    typedef logic [3:0] idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP,
        INPUT
    } seq_state_t;

    localparam int unsigned SEQ_DEPTH = 16;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module seq_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/seq_player.sv
// Plays a stored symbol sequence to the display, then checks the player's presses against it.
module seq_player
    import game_pkg::*;
#(
    parameter int unsigned ON_CYCLES      = 8,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] seq_len,
    output logic [3:0] rd_sel,
    input  logic [2:0] rd_data,
    output logic       show_valid,
    output logic [2:0] show_sym,
    input  logic       btn_valid,
    input  logic [2:0] btn_sym,
    output logic       busy,
    output logic       pass,
    output logic       fail
);

    localparam int unsigned TW = $clog2(max3(ON_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)) + 1;

    // Loads are duration-1 so the last cycle of each phase is the one where done is seen.
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t state_q, state_d;
    idx_t       idx_q, idx_d;
    idx_t       last_q, last_d;
    logic       pass_q, pass_d;
    logic       fail_q, fail_d;
    logic       tmr_load;
    logic [TW-1:0] tmr_val;
    logic       tmr_done;

    seq_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        pass_d   = 1'b0;
        fail_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    last_d   = seq_len;
                    idx_d    = '0;
                    state_d  = SHOW;
                    tmr_load = 1'b1;
                    tmr_val  = ON_LOAD;
                end
            end
            SHOW: begin
                if (tmr_done) begin
                    state_d  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
            end
            GAP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (idx_q != last_q) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SHOW;
                        tmr_val = ON_LOAD;
                    end else begin
                        idx_d   = '0;
                        state_d = INPUT;
                        tmr_val = TO_LOAD;
                    end
                end
            end
            INPUT: begin
                // A press landing on the final timeout cycle is still judged on its symbol.
                if (btn_valid) begin
                    if (btn_sym != rd_data) begin
                        fail_d  = 1'b1;
                        state_d = IDLE;
                    end else if (idx_q == last_q) begin
                        pass_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = TO_LOAD;
                    end
                end else if (tmr_done) begin
                    fail_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign rd_sel     = idx_q;
    assign busy       = (state_q != IDLE);
    assign show_valid = (state_q == SHOW);
    assign show_sym   = show_valid ? rd_data : 3'd0;
    assign pass       = pass_q;
    assign fail       = fail_q;

endmodule

// File: tb/tb_seq_player.sv
// Random rounds against a timing model of the player; a negedge monitor scores display and results.
module tb_seq_player;
    import game_pkg::*;

    localparam int unsigned ON  = 8;
    localparam int unsigned GP  = 4;
    localparam int unsigned TO  = 64;
    localparam int          PER = ON + GP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] seq_len = 4'd0;
    logic [3:0] rd_sel;
    logic [2:0] rd_data;
    logic       show_valid;
    logic [2:0] show_sym;
    logic       btn_valid = 1'b0;
    logic [2:0] btn_sym = 3'd0;
    logic       busy;
    logic       pass;
    logic       fail;

    sym_t mem [SEQ_DEPTH];
    assign rd_data = mem[rd_sel];

    seq_player #(
        .ON_CYCLES      (ON),
        .GAP_CYCLES     (GP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seq_len    (seq_len),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .show_valid (show_valid),
        .show_sym   (show_sym),
        .btn_valid  (btn_valid),
        .btn_sym    (btn_sym),
        .busy       (busy),
        .pass       (pass),
        .fail       (fail)
    );

    always #5 clk = ~clk;

    // cyc counts rising edges; "cycle c" is the interval ending at edge c.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct { int cyc; sym_t sym; } show_ev_t;
    typedef struct { int cyc; logic is_pass; } res_ev_t;
    show_ev_t show_q [$];
    res_ev_t  res_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc + 1);
        end
    endtask

    // Monitor: pops expectations whenever the DUT shows a symbol or pulses a result.
    logic     prev_sv = 1'b0;
    int       run_len = 0;
    int       mcur;
    show_ev_t sev;
    res_ev_t  rev;
    always @(negedge clk) begin
        mcur = cyc + 1;
        if (rst) begin
            prev_sv = 1'b0;
            run_len = 0;
        end else begin
            if (show_valid && !prev_sv) begin
                if (show_q.size() == 0) begin
                    check("show_unexpected", 1, 0);
                end else begin
                    sev = show_q.pop_front();
                    check("show_cycle", mcur, sev.cyc);
                    check("show_sym", show_sym, sev.sym);
                end
                run_len = 0;
            end
            if (show_valid) run_len++;
            if (!show_valid && prev_sv) begin
                check("show_len", run_len, ON);
                check("show_sym_blank", show_sym, 0);
            end
            if (pass || fail) begin
                check("pulse_exclusive", pass & fail, 0);
                check("busy_at_result", busy, 0);
                if (res_q.size() == 0) begin
                    check("result_unexpected", 1, 0);
                end else begin
                    rev = res_q.pop_front();
                    check("result_cycle", mcur, rev.cyc);
                    check("result_kind", pass, rev.is_pass);
                end
            end
            prev_sv = show_valid;
        end
    end

    function automatic int now();
        return cyc + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (now() < c) step();
    endtask

    // kind: 0 all correct, 1 wrong symbol at bad_j, 2 silence at bad_j.
    task automatic run_round(input int n, input int kind, input int bad_j, input bit keep_mem,
                             input bit noise, input bit long_first);
        int t, prev, p, d;
        show_ev_t se;
        res_ev_t  re;
        if (!keep_mem) for (int k = 0; k < SEQ_DEPTH; k++) mem[k] = sym_t'($urandom_range(0, 7));
        start   = 1'b1;
        seq_len = 4'(n - 1);
        t = now();
        for (int k = 0; k < n; k++) begin
            se.cyc = t + 1 + k * PER;
            se.sym = mem[k];
            show_q.push_back(se);
        end
        step();
        start   = 1'b0;
        seq_len = 4'($urandom);
        if (noise) begin
            wait_until(t + 3);
            start     = 1'b1;
            btn_valid = 1'b1;
            btn_sym   = 3'($urandom);
            step();
            start     = 1'b0;
            btn_valid = 1'b0;
        end
        prev = t + n * PER;
        for (int j = 0; j < n; j++) begin
            if (kind == 2 && j == bad_j) begin
                re.cyc = prev + TO + 1;
                re.is_pass = 1'b0;
                res_q.push_back(re);
                wait_until(prev + TO + 1);
                return;
            end
            if (long_first && j == 0) d = TO;
            else d = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(1, 12);
            p = prev + d;
            wait_until(p);
            btn_valid = 1'b1;
            if (kind == 1 && j == bad_j) begin
                btn_sym = mem[j] ^ sym_t'($urandom_range(1, 7));
                re.cyc = p + 1;
                re.is_pass = 1'b0;
                res_q.push_back(re);
                step();
                btn_valid = 1'b0;
                return;
            end
            btn_sym = mem[j];
            if (j == n - 1) begin
                re.cyc = p + 1;
                re.is_pass = 1'b1;
                res_q.push_back(re);
            end
            step();
            btn_valid = 1'b0;
            prev = p;
        end
    endtask

    // Abort a round with rst in cycle t+off; only symbols already begun are expected.
    task automatic reset_round(input int n, input int off);
        int t;
        show_ev_t se;
        for (int k = 0; k < SEQ_DEPTH; k++) mem[k] = sym_t'($urandom_range(0, 7));
        start   = 1'b1;
        seq_len = 4'(n - 1);
        t = now();
        for (int k = 0; k < n; k++) begin
            if (t + 1 + k * PER < t + off) begin
                se.cyc = t + 1 + k * PER;
                se.sym = mem[k];
                show_q.push_back(se);
            end
        end
        step();
        start = 1'b0;
        wait_until(t + off);
        #2;
        rst = 1'b1;
        #1;
        check("rst_show_valid", show_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_sel", rd_sel, 0);
        check("rst_no_result", {pass, fail}, 0);
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < SEQ_DEPTH; k++) mem[k] = 3'd0;
        repeat (3) step();
        check("reset_rd_sel", rd_sel, 0);
        check("reset_show_valid", show_valid, 0);
        check("reset_show_sym", show_sym, 0);
        check("reset_busy", busy, 0);
        check("reset_pass_fail", {pass, fail}, 0);
        rst = 1'b0;
        step();
        check("idle_busy", busy, 0);

        mem[0] = 3'd3; mem[1] = 3'd5; mem[2] = 3'd1;
        run_round(3, 0, 0, 1'b1, 1'b0, 1'b0);
        step();
        mem[0] = 3'd3; mem[1] = 3'd5; mem[2] = 3'd1;
        run_round(3, 1, 1, 1'b1, 1'b0, 1'b0);
        step();
        run_round(1, 2, 0, 1'b0, 1'b0, 1'b0);
        run_round(1, 0, 0, 1'b0, 1'b0, 1'b1);
        run_round(16, 0, 0, 1'b0, 1'b0, 1'b0);
        run_round(4, 0, 0, 1'b0, 1'b1, 1'b0);
        reset_round(5, PER + ON + 2);
        reset_round(3, 4);
        run_round(3, 0, 0, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 25; r++) begin
            int n, kind;
            n    = $urandom_range(1, 16);
            kind = $urandom_range(0, 2);
            run_round(n, kind, $urandom_range(0, n - 1), 1'b0, ($urandom_range(0, 3) == 0),
                      1'b0);
            repeat ($urandom_range(0, 3)) step();
        end

        repeat (5) step();
        check("show_queue_drained", show_q.size(), 0);
        check("result_queue_drained", res_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
